// File: rtl/rfile_sb.sv
// NREGS x XLEN register file with two registered read ports, one writeback port
// and a write-pending scoreboard. Define RFILE_BYPASS_EN for same-edge write->read forwarding.
module rfile_sb_cell #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic            set,
  input  logic            clr,
  output logic [XLEN-1:0] q,
  output logic            busy
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (we) q <= wdata;
      // a same-cycle issue is younger than the retiring write, so set wins
      if (set)      busy <= 1'b1;
      else if (clr) busy <= 1'b0;
    end
  end
endmodule

module rfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   src_rs1,
  input  logic            rs1_valid,
  input  logic [AW-1:0]   src_rs2,
  input  logic            rs2_valid,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_valid,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  output logic [AW:0]     pending
);
  localparam int NREGS = 1 << AW;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;
  logic [AW:0]                pend_nxt;
  logic [XLEN-1:0]            rd1_val, rd2_val;
  logic                       hz1, hz2, hz_iss;
  logic                       wr_live;

  assign wr_live = rd_valid && (rd != '0);

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      if (i == 0) begin : g_x0
        assign regs[i]     = '0;
        assign busy[i]     = 1'b0;
        assign busy_nxt[i] = 1'b0;
      end else begin : g_xn
        logic we, set, clr;
        assign we  = rd_valid && (rd == AW'(i));
        assign clr = we;
        assign set = issue_valid && (issue_rd == AW'(i));
        assign busy_nxt[i] = set | (busy[i] & ~clr);
        rfile_sb_cell #(.XLEN(XLEN)) u_cell (
          .clk   (clk),
          .reset (reset),
          .we    (we),
          .wdata (rd_data),
          .set   (set),
          .clr   (clr),
          .q     (regs[i]),
          .busy  (busy[i])
        );
      end
    end
  endgenerate

  always_comb begin
    pend_nxt = '0;
    for (int k = 0; k < NREGS; k++) pend_nxt = pend_nxt + (AW+1)'(busy_nxt[k]);
  end

`ifdef RFILE_BYPASS_EN
  logic fwd1, fwd2, fwd_iss;
  assign fwd1    = wr_live && (rd == src_rs1);
  assign fwd2    = wr_live && (rd == src_rs2);
  assign fwd_iss = wr_live && (rd == issue_rd);
  assign rd1_val = fwd1 ? rd_data : regs[src_rs1];
  assign rd2_val = fwd2 ? rd_data : regs[src_rs2];
  assign hz1     = busy[src_rs1]  && (src_rs1  != '0) && !fwd1;
  assign hz2     = busy[src_rs2]  && (src_rs2  != '0) && !fwd2;
  assign hz_iss  = busy[issue_rd] && (issue_rd != '0) && !fwd_iss;
`else
  // without forwarding the consumer waits until the value lands in the array
  logic unused_wr;
  assign unused_wr = wr_live;
  assign rd1_val   = regs[src_rs1];
  assign rd2_val   = regs[src_rs2];
  assign hz1       = busy[src_rs1]  && (src_rs1  != '0);
  assign hz2       = busy[src_rs2]  && (src_rs2  != '0);
  assign hz_iss    = busy[issue_rd] && (issue_rd != '0);
`endif

  assign stall = (rs1_valid & hz1) | (rs2_valid & hz2) | (issue_valid & hz_iss);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1     <= '0;
      rs2     <= '0;
      pending <= '0;
    end else begin
      if (rs1_valid) rs1 <= rd1_val;
      if (rs2_valid) rs2 <= rd2_val;
      pending <= pend_nxt;
    end
  end
endmodule
